// File: rtl/iis_pkg.sv
// rtl/iis_pkg.sv - shared types and helpers for the stereo serial-audio receiver
// Purpose: receiver FSM state type, slot bit-counter width helper, DATA_W limits.
// Ports: none (package).
package iis_pkg;

  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } iis_state_e;

  // Width of a counter able to hold SLOT_W (it saturates at all-ones).
  function automatic int slot_cnt_w(input int slot_w);
    return (slot_w < 1) ? 1 : $clog2(slot_w + 1);
  endfunction

endpackage

// File: rtl/iis_sync_edge.sv
// rtl/iis_sync_edge.sv - multi-flop synchroniser with rising-edge detect
// Purpose: brings one asynchronous pin into the clk domain through STAGES flops and
//          flags the cycle in which the synchronised level goes 0 -> 1.
// Ports:   clk  in  system clock
//          rst  in  asynchronous active-high reset
//          d    in  asynchronous input
//          q    out synchronised level
//          rise out one-cycle pulse on synchronised 0 -> 1
module iis_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              q_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      q_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_prev <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~q_prev;

endmodule

// File: rtl/iis_rx_stereo.sv
// rtl/iis_rx_stereo.sv - stereo I2S / left-justified receiver with valid/ready pair output
// Purpose: oversamples bclk/lrck/sdata on pclk, deserialises left+right slots MSB first and
//          presents each frame as one stereo pair. Optional peak meters when IIS_RX_PEAK_EN
//          is defined.
// Ports:   pclk, preset            system clock, async active-high reset
//          mode_lj                 0 = I2S, 1 = left-justified (latched when leaving SYNC)
//          bclk, lrck, sdata       asynchronous serial-audio pins
//          out_valid/out_ready     pair handshake; out_left/out_right the pair
//          overrun                 pulse: pair replaced before it was taken
//          slot_err                pulse: committed slot length differed from SLOT_W
//          peak_left/peak_right    (IIS_RX_PEAK_EN) absolute peak per channel
//          peak_clr                (IIS_RX_PEAK_EN) clears both peaks
module iis_rx_stereo
  import iis_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SLOT_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              mode_lj,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              sdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              overrun,
  output logic              slot_err
`ifdef IIS_RX_PEAK_EN
  ,
  input  logic              peak_clr,
  output logic [DATA_W-1:0] peak_left,
  output logic [DATA_W-1:0] peak_right
`endif
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("iis_rx_stereo: DATA_W out of range");
  end

  localparam int                CW       = slot_cnt_w(SLOT_W);
  localparam logic [CW-1:0]     CNT_MAX  = '1;
  localparam logic [CW-1:0]     SLOT_LEN = CW'(SLOT_W);
  localparam logic [DATA_W-1:0] MSB_ONLY = {1'b1, {(DATA_W-1){1'b0}}};

  logic tick, lrck_s, sdata_s;
  logic bclk_s_unused, lrck_rise_unused, sdata_rise_unused;

  iis_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(pclk), .rst(preset), .d(bclk), .q(bclk_s_unused), .rise(tick));
  iis_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(pclk), .rst(preset), .d(lrck), .q(lrck_s), .rise(lrck_rise_unused));
  iis_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(pclk), .rst(preset), .d(sdata), .q(sdata_s), .rise(sdata_rise_unused));

  iis_state_e        state;
  logic              mode_q, lrck_prev, pair_ld;
  logic [DATA_W-1:0] sr, mask, left_hold, pend_left, pend_right;
  logic [CW-1:0]     bit_cnt;

  // lrck edges are judged tick-to-tick, so a glitch between bclk rises is invisible.
  logic lr_rise, lr_fall;
  assign lr_rise = tick &  lrck_s & ~lrck_prev;
  assign lr_fall = tick & ~lrck_s &  lrck_prev;

  // mask is one-hot on the next bit position to fill; it empties after DATA_W bits so
  // any longer slot leaves the captured word untouched.
  logic [DATA_W-1:0] sr_app;
  logic [CW-1:0]     cnt_app;
  assign sr_app  = sdata_s ? (sr | mask) : sr;
  assign cnt_app = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;

  // I2S: the edge-tick bit closes the old slot. LJ: it opens the new one.
  logic [DATA_W-1:0] word_c;
  logic [CW-1:0]     wcnt_c;
  assign word_c = mode_q ? sr      : sr_app;
  assign wcnt_c = mode_q ? bit_cnt : cnt_app;

  logic              start_lj;
  logic [DATA_W-1:0] first_sr, first_mask;
  logic [CW-1:0]     first_cnt;
  assign start_lj   = (state == ST_SYNC) ? mode_lj : mode_q;
  assign first_sr   = (start_lj && sdata_s) ? MSB_ONLY : '0;
  assign first_mask = start_lj ? (MSB_ONLY >> 1) : MSB_ONLY;
  assign first_cnt  = start_lj ? CW'(1) : '0;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= ST_SYNC;
      mode_q     <= 1'b0;
      lrck_prev  <= 1'b0;
      sr         <= '0;
      mask       <= '0;
      bit_cnt    <= '0;
      left_hold  <= '0;
      pend_left  <= '0;
      pend_right <= '0;
      pair_ld    <= 1'b0;
      slot_err   <= 1'b0;
    end else begin
      pair_ld  <= 1'b0;
      slot_err <= 1'b0;
      if (tick) begin
        lrck_prev <= lrck_s;
        case (state)
          ST_SYNC: begin
            if (lr_fall) begin
              state   <= ST_LEFT;
              mode_q  <= mode_lj;
              sr      <= first_sr;
              mask    <= first_mask;
              bit_cnt <= first_cnt;
            end
          end
          ST_LEFT, ST_RIGHT: begin
            if ((state == ST_LEFT && lr_rise) || (state == ST_RIGHT && lr_fall)) begin
              slot_err <= (wcnt_c != SLOT_LEN);
              sr       <= first_sr;
              mask     <= first_mask;
              bit_cnt  <= first_cnt;
              if (state == ST_LEFT) begin
                left_hold <= word_c;
                state     <= ST_RIGHT;
              end else begin
                pend_left  <= left_hold;
                pend_right <= word_c;
                pair_ld    <= 1'b1;
                state      <= ST_LEFT;
              end
            end else begin
              sr      <= sr_app;
              mask    <= mask >> 1;
              bit_cnt <= cnt_app;
            end
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

  // A load coinciding with an accept keeps valid high; a load onto an untaken pair overruns.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= pair_ld & out_valid & ~out_ready;
      if (pair_ld) begin
        out_left  <= pend_left;
        out_right <= pend_right;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef IIS_RX_PEAK_EN
  // Magnitude of a two's-complement sample; the most negative value clips to max positive.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] w);
    if (!w[DATA_W-1]) return w;
    if (w == MSB_ONLY) return ~MSB_ONLY;
    return -w;
  endfunction

  logic [DATA_W-1:0] word_abs;
  logic              commit_left, commit_right;
  assign word_abs     = abs_sat(word_c);
  assign commit_left  = (state == ST_LEFT)  & lr_rise;
  assign commit_right = (state == ST_RIGHT) & lr_fall;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else if (peak_clr) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else begin
      if (commit_left && word_abs > peak_left)   peak_left  <= word_abs;
      if (commit_right && word_abs > peak_right) peak_right <= word_abs;
    end
  end
`endif

endmodule

// File: tb/tb_iis_rx_stereo.sv
// tb/tb_iis_rx_stereo.sv - self-checking bench for iis_rx_stereo
module tb_iis_rx_stereo;

  localparam int DW = 16;
  localparam int SW = 16;

  logic          pclk = 1'b0;
  logic          preset, mode_lj, bclk, lrck, sdata, out_ready;
  logic          out_valid, overrun, slot_err;
  logic [DW-1:0] out_left, out_right;
`ifdef IIS_RX_PEAK_EN
  logic          peak_clr;
  logic [DW-1:0] peak_left, peak_right;
`endif

  always #5 pclk = ~pclk;

  iis_rx_stereo #(.DATA_W(DW), .SLOT_W(SW), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .preset(preset), .mode_lj(mode_lj),
    .bclk(bclk), .lrck(lrck), .sdata(sdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_right(out_right),
    .overrun(overrun), .slot_err(slot_err)
`ifdef IIS_RX_PEAK_EN
    , .peak_clr(peak_clr), .peak_left(peak_left), .peak_right(peak_right)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [DW-1:0] got_l[$], got_r[$];
  int got_err, got_ov;

  always @(negedge pclk) begin
    if (!preset) begin
      if (out_valid && out_ready) begin
        got_l.push_back(out_left);
        got_r.push_back(out_right);
      end
      if (slot_err) got_err++;
      if (overrun)  got_ov++;
    end
  end

  bit ready_rand = 1'b0;
  initial forever begin
    @(posedge pclk);
    #1;
    if (ready_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stream construction ----------------
  typedef struct { int len; logic [31:0] val; } slot_t;
  slot_t slots[$];
  bit s_lr[$], s_sd[$];

  // Slots alternate left/right after a short right-channel preamble; a short left trailer
  // supplies the closing lrck fall. I2S places each data bit one bclk after its lrck bit.
  task automatic build(input bit lj);
    bit d[$];
    s_lr.delete();
    s_sd.delete();
    for (int i = 0; i < 5; i++) begin s_lr.push_back(1'b1); d.push_back(1'b0); end
    for (int k = 0; k < slots.size(); k++)
      for (int j = 0; j < slots[k].len; j++) begin
        s_lr.push_back(k % 2 == 1);
        d.push_back(slots[k].val[slots[k].len - 1 - j]);
      end
    for (int i = 0; i < 3; i++) begin s_lr.push_back(1'b0); d.push_back(1'b0); end
    for (int i = 0; i < s_lr.size(); i++)
      s_sd.push_back(lj ? d[i] : ((i == 0) ? 1'b0 : d[i - 1]));
  endtask

  task automatic play(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      bclk  = 1'b0;
      lrck  = s_lr[i];
      sdata = s_sd[i];
      repeat (4) @(posedge pclk);
      #1 bclk = 1'b1;
      repeat (4) @(posedge pclk);
      #1;
    end
    bclk = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Works only from the pin streams: split lrck into runs, each run is one slot; the
  // receiver locks on the first run that starts with lrck low, and a slot is complete
  // once the following run exists.
  logic [DW-1:0] exp_l[$], exp_r[$];
  int exp_err;

  function automatic logic [DW-1:0] slot_word(input int a, input int len, input bit lj);
    logic [DW-1:0] w;
    int off;
    w = '0;
    off = lj ? 0 : 1;
    for (int j = 0; j < len && j < DW; j++) w[DW - 1 - j] = s_sd[a + off + j];
    return w;
  endfunction

  task automatic model(input bit lj);
    int st[$];
    int k0;
    exp_l.delete();
    exp_r.delete();
    exp_err = 0;
    st.push_back(0);
    for (int i = 1; i < s_lr.size(); i++) if (s_lr[i] != s_lr[i - 1]) st.push_back(i);
    st.push_back(s_lr.size());
    k0 = 1;
    while (k0 < st.size() - 1 && s_lr[st[k0]] != 1'b0) k0++;
    for (int k = k0; k < st.size() - 2; k++) if (st[k + 1] - st[k] != SW) exp_err++;
    for (int k = k0; k + 1 < st.size() - 2; k += 2) begin
      exp_l.push_back(slot_word(st[k], st[k + 1] - st[k], lj));
      exp_r.push_back(slot_word(st[k + 1], st[k + 2] - st[k + 1], lj));
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_model_npairs"}, got_l.size(), exp_l.size());
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      chk($sformatf("%s_model_left%0d", tag, i), got_l[i], exp_l[i]);
      chk($sformatf("%s_model_right%0d", tag, i), got_r[i], exp_r[i]);
    end
    chk({tag, "_model_slot_err"}, got_err, exp_err);
    chk({tag, "_overrun"}, got_ov, 0);
  endtask

  task automatic do_reset(input bit lj);
    preset  = 1'b1;
    bclk    = 1'b0;
    lrck    = 1'b1;
    sdata   = 1'b0;
    mode_lj = lj;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    got_l.delete();
    got_r.delete();
    got_err = 0;
    got_ov  = 0;
    repeat (3) @(posedge pclk);
    #1;
  endtask

  task automatic add_frame(input int len, input logic [31:0] lv, input logic [31:0] rv);
    slot_t s;
    s.len = len; s.val = lv; slots.push_back(s);
    s.len = len; s.val = rv; slots.push_back(s);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit tx_lj; bit rx_lj; int len; logic [31:0] lv; logic [31:0] rv; int frames;
    int exp_pairs; logic [DW-1:0] exp_l; logic [DW-1:0] exp_r; int exp_errs;
  } vec_t;

  function automatic vec_t mk(input bit t, input bit r, input int len, input logic [31:0] lv,
                              input logic [31:0] rv, input int np, input logic [DW-1:0] el,
                              input logic [DW-1:0] er, input int ne);
    vec_t v;
    v.tx_lj = t; v.rx_lj = r; v.len = len; v.lv = lv; v.rv = rv; v.frames = 4;
    v.exp_pairs = np; v.exp_l = el; v.exp_r = er; v.exp_errs = ne;
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    vecs[0] = mk(0, 0, 16, 32'h55AA,     32'h00FF,     4, 16'h55AA, 16'h00FF, 0);
    vecs[1] = mk(1, 1, 16, 32'h55AA,     32'h00FF,     4, 16'h55AA, 16'h00FF, 0);
    vecs[2] = mk(0, 1, 16, 32'h55AA,     32'h00FF,     4, 16'hAAD5, 16'h007F, 0);
    vecs[3] = mk(1, 0, 16, 32'h55AA,     32'h00FF,     4, 16'hAB54, 16'h01FE, 0);
    vecs[4] = mk(0, 0, 32, 32'h1234ABCD, 32'hFEDC5678, 4, 16'h1234, 16'hFEDC, 8);
    vecs[5] = mk(1, 1, 32, 32'h1234ABCD, 32'hFEDC5678, 4, 16'h1234, 16'hFEDC, 8);
    vecs[6] = mk(0, 0, 12, 32'hABC,      32'h123,      4, 16'hABC0, 16'h1230, 8);

    out_ready = 1'b1;
`ifdef IIS_RX_PEAK_EN
    peak_clr = 1'b0;
`endif
    preset = 1'b1; bclk = 1'b0; lrck = 1'b0; sdata = 1'b0; mode_lj = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_left",  out_left,  0);
    chk("rst_out_right", out_right, 0);
    chk("rst_overrun",   overrun,   0);
    chk("rst_slot_err",  slot_err,  0);
`ifdef IIS_RX_PEAK_EN
    chk("rst_peak_left",  peak_left,  0);
    chk("rst_peak_right", peak_right, 0);
`endif

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      slots.delete();
      for (int f = 0; f < vecs[v].frames; f++) add_frame(vecs[v].len, vecs[v].lv, vecs[v].rv);
      build(vecs[v].tx_lj);
      do_reset(vecs[v].rx_lj);
      play(0, s_lr.size());
      repeat (20) @(posedge pclk);
      @(negedge pclk);
      chk({tag, "_npairs"}, got_l.size(), vecs[v].exp_pairs);
      if (got_l.size() > 0) begin
        chk({tag, "_last_left"},  got_l[got_l.size() - 1], vecs[v].exp_l);
        chk({tag, "_last_right"}, got_r[got_r.size() - 1], vecs[v].exp_r);
      end
      chk({tag, "_slot_err"}, got_err, vecs[v].exp_errs);
      model(vecs[v].rx_lj);
      cmp_model(tag);
    end

    // Overrun: consumer stalled over three frames.
    slots.delete();
    add_frame(16, 32'h1111, 32'h2222);
    add_frame(16, 32'h3333, 32'h4444);
    add_frame(16, 32'h5555, 32'h6666);
    build(1'b0);
    out_ready = 1'b0;
    do_reset(1'b0);
    play(0, s_lr.size());
    repeat (20) @(posedge pclk);
    @(negedge pclk);
    chk("ovr_count", got_ov, 2);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_left",  out_left,  16'h5555);
    chk("ovr_right", out_right, 16'h6666);
    @(posedge pclk);
    #1 out_ready = 1'b1;
    @(posedge pclk);
    #1 out_ready = 1'b0;
    @(negedge pclk);
    chk("ovr_taken_valid", out_valid, 0);
    chk("ovr_taken_count", got_l.size(), 1);

    // Reset in the middle of frame 2's left slot while frame 1's pair is still held.
    slots.delete();
    add_frame(16, 32'h1357, 32'h2468);
    add_frame(16, 32'h9ABC, 32'hDEF0);
    add_frame(16, 32'h0F0F, 32'hF0F0);
    add_frame(16, 32'hC3A5, 32'h5A3C);
    build(1'b0);
    out_ready = 1'b0;
    do_reset(1'b0);
    play(0, 5 + 32 + 6);
    repeat (20) @(posedge pclk);
    @(negedge pclk);
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_left",  out_left,  16'h1357);
    preset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_left",  out_left,  0);
    chk("mid_rst_right", out_right, 0);
    @(posedge pclk);
    #1 preset = 1'b0;
    out_ready = 1'b1;
    play(5 + 32 + 6, s_lr.size());
    repeat (20) @(posedge pclk);
    @(negedge pclk);
    chk("mid_npairs", got_l.size(), 2);
    if (got_l.size() >= 2) begin
      chk("mid_p0_left",  got_l[0], 16'h0F0F);
      chk("mid_p0_right", got_r[0], 16'hF0F0);
      chk("mid_p1_left",  got_l[1], 16'hC3A5);
      chk("mid_p1_right", got_r[1], 16'h5A3C);
    end

    // Randomised slot lengths, data, modes and consumer back-pressure.
    for (int it = 0; it < 8; it++) begin
      bit rxm, txm;
      rxm = 1'($urandom_range(0, 1));
      txm = ($urandom_range(0, 3) == 0) ? ~rxm : rxm;
      slots.delete();
      for (int f = 0; f < 3; f++)
        add_frame($urandom_range(10, 22), $urandom, $urandom);
      for (int k = 0; k < slots.size(); k++) slots[k].len = $urandom_range(10, 22);
      build(txm);
      do_reset(rxm);
      ready_rand = 1'b1;
      play(0, s_lr.size());
      repeat (20) @(posedge pclk);
      ready_rand = 1'b0;
      out_ready  = 1'b1;
      repeat (4) @(posedge pclk);
      @(negedge pclk);
      model(rxm);
      cmp_model($sformatf("rnd%0d", it));
    end

`ifdef IIS_RX_PEAK_EN
    slots.delete();
    add_frame(16, 32'h8000, 32'h7FF0);
    add_frame(16, 32'h0010, 32'hFFFF);
    build(1'b0);
    do_reset(1'b0);
    play(0, s_lr.size());
    repeat (20) @(posedge pclk);
    @(negedge pclk);
    chk("peak_left",  peak_left,  16'h7FFF);
    chk("peak_right", peak_right, 16'h7FF0);
    @(posedge pclk);
    #1 peak_clr = 1'b1;
    @(posedge pclk);
    #1 peak_clr = 1'b0;
    @(negedge pclk);
    chk("peak_clr_left",  peak_left,  0);
    chk("peak_clr_right", peak_right, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
